// File: rtl/ex_wb_buffer_pkg.sv
// Shared definitions for the execute-to-writeback elastic buffer.
// FSM encoding plus result bundle field offsets used by writeback.
package ex_wb_buffer_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam int RES_W      = 64;
    localparam int RES1_LSB   = 0;
    localparam int RES2_LSB   = 64;
    localparam int RES3_LSB   = 128;
    localparam int RES4_LSB   = 192;
    localparam int DEST_LSB   = 256;
    localparam int DEST_W     = 32;
    localparam int TYPE_LSB   = 288;
    localparam int TYPE_W     = 16;
    localparam int EFLAGS_LSB = 304;
    localparam int EFLAGS_W   = 32;
    localparam int EIP_LSB    = 336;
    localparam int EIP_W      = 32;
    localparam int P_OP_LSB   = 368;
    localparam int P_OP_W     = 8;

endpackage

// File: rtl/ex_wb_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module ex_wb_buffer_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count qualifying cycles, holding at the maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ex_wb_buffer.sv
// Two-entry elastic buffer between execute and writeback.
// Squashes wrong-path results after a mispredict; flushable.
module ex_wb_buffer
    import ex_wb_buffer_pkg::*;
#(
    parameter int DW  = 512,
    parameter int SCW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    input  logic           in_br_mispred,
    output logic           in_stall,
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    input  logic           out_stall,
    input  logic           resteer_done,
    input  logic           flush,
    output logic           squashing,
    output logic [SCW-1:0] stall_cycles,
    input  logic           stall_clr
);

    logic [1:0]    count_q;
    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    state_t        state_q;
    state_t        state_d;
    logic          squash_drop;
    logic          push;
    logic          pop;

    assign in_stall    = (count_q == 2'd2);
    assign out_valid   = (count_q != 2'd0);
    assign out_data    = head_q;
    assign squashing   = (state_q == SQUASH);
    assign squash_drop = squashing & in_valid & ~resteer_done;
    assign push        = in_valid & ~in_stall & ~squash_drop;
    assign pop         = out_valid & ~out_stall;

    // Squash state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next squash state: flush first, then a stored mispredict, then resteer.
    always_comb begin
        state_d = state_q;
        priority case (1'b1)
            flush:                  state_d = RUN;
            push && in_br_mispred:  state_d = SQUASH;
            resteer_done:           state_d = RUN;
            default:                state_d = state_q;
        endcase
    end

    // Entry storage and occupancy; a full buffer can only pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q  <= in_data;
                        count_q <= 2'd1;
                    end else begin
                        tail_q  <= in_data;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    head_q <= in_data;
                end
                default: begin
                end
            endcase
        end
    end

    ex_wb_buffer_sat_counter #(
        .W(SCW)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_valid & in_stall),
        .clr   (stall_clr),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Bench for ex_wb_buffer: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_ex_wb_buffer;

    localparam int DW  = 512;
    localparam int SCW = 16;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_br_mispred;
    logic           in_stall;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_stall;
    logic           resteer_done;
    logic           flush;
    logic           squashing;
    logic [SCW-1:0] stall_cycles;
    logic           stall_clr;

    int n_pass  = 0;
    int n_total = 0;

    ex_wb_buffer #(
        .DW  (DW),
        .SCW (SCW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_br_mispred (in_br_mispred),
        .in_stall      (in_stall),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_stall     (out_stall),
        .resteer_done  (resteer_done),
        .flush         (flush),
        .squashing     (squashing),
        .stall_cycles  (stall_cycles),
        .stall_clr     (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        mp;
        logic        os;
        logic        rs;
        logic        fl;
        logic        clr;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_is;
        logic        e_sq;
        logic [15:0] e_sc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic iv, input logic [31:0] d, input logic mp,
        input logic os, input logic rs, input logic fl, input logic clr,
        input logic e_ov, input logic [31:0] e_od, input logic e_is,
        input logic e_sq, input logic [15:0] e_sc);
        vec_t v;
        v.iv = iv; v.d = d; v.mp = mp; v.os = os; v.rs = rs;
        v.fl = fl; v.clr = clr; v.e_ov = e_ov; v.e_od = e_od;
        v.e_is = e_is; v.e_sq = e_sq; v.e_sc = e_sc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, want);
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d,
                         input logic mp, input logic os, input logic rs,
                         input logic fl, input logic clr);
        in_valid      = iv;
        in_data       = d;
        in_br_mispred = mp;
        out_stall     = os;
        resteer_done  = rs;
        flush         = fl;
        stall_clr     = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic ov,
                           input logic [DW-1:0] od, input logic is,
                           input logic sq, input logic [15:0] sc);
        chk({nm, "_ov"}, DW'(out_valid), DW'(ov));
        chk({nm, "_od"}, out_data, od);
        chk({nm, "_is"}, DW'(in_stall), DW'(is));
        chk({nm, "_sq"}, DW'(squashing), DW'(sq));
        chk({nm, "_sc"}, DW'(stall_cycles), DW'(sc));
    endtask

    logic [DW-1:0] mq[$];
    logic          m_sq;
    logic [15:0]   m_sc;

    initial begin
        logic [DW-1:0] rd;
        logic iv, mp, os, rs, fl, clr, m_full, acc;

        drive(F, '0, F, F, F, F, F);
        rst = 1'b0;
        #3;
        chk_all("reset", F, '0, F, F, 16'd0);
        #4;
        rst = 1'b1;

        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(T, 32'(k), F, F, F, F, F, T, 32'(k), F, F, 0));
        tbl.push_back(mk(F, 0, F, F, F, F, F, F, 32'h8, F, F, 0));
        tbl.push_back(mk(T, 32'hA, F, T, F, F, F, T, 32'hA, F, F, 0));
        tbl.push_back(mk(T, 32'hB, F, T, F, F, F, T, 32'hA, T, F, 0));
        tbl.push_back(mk(T, 32'hC, F, T, F, F, F, T, 32'hA, T, F, 1));
        tbl.push_back(mk(T, 32'hC, F, T, F, F, F, T, 32'hA, T, F, 2));
        tbl.push_back(mk(T, 32'hC, F, F, F, F, F, T, 32'hB, F, F, 3));
        tbl.push_back(mk(T, 32'hC, F, F, F, F, F, T, 32'hC, F, F, 3));
        tbl.push_back(mk(F, 0, F, F, F, F, F, F, 32'hC, F, F, 3));
        tbl.push_back(mk(F, 0, F, F, F, F, T, F, 32'hC, F, F, 0));
        tbl.push_back(mk(T, 32'h10, T, F, F, F, F, T, 32'h10, F, T, 0));
        tbl.push_back(mk(T, 32'h11, F, F, F, F, F, F, 32'h10, F, T, 0));
        tbl.push_back(mk(T, 32'h12, F, F, F, F, F, F, 32'h10, F, T, 0));
        tbl.push_back(mk(T, 32'h20, F, F, T, F, F, T, 32'h20, F, F, 0));
        tbl.push_back(mk(F, 0, F, F, F, F, F, F, 32'h20, F, F, 0));
        tbl.push_back(mk(T, 32'h30, F, T, F, F, F, T, 32'h30, F, F, 0));
        tbl.push_back(mk(T, 32'h31, F, T, F, F, F, T, 32'h30, T, F, 0));
        tbl.push_back(mk(T, 32'h32, F, T, F, T, F, F, 32'h30, F, F, 1));
        tbl.push_back(mk(T, 32'h33, F, F, F, F, F, T, 32'h33, F, F, 1));
        tbl.push_back(mk(F, 0, F, F, F, F, F, F, 32'h33, F, F, 1));
        tbl.push_back(mk(T, 32'h50, T, F, F, F, F, T, 32'h50, F, T, 1));
        tbl.push_back(mk(T, 32'h51, F, F, F, T, F, F, 32'h50, F, F, 1));
        tbl.push_back(mk(T, 32'h52, F, F, F, F, F, T, 32'h52, F, F, 1));
        tbl.push_back(mk(F, 0, F, F, F, F, T, F, 32'h52, F, F, 0));
        tbl.push_back(mk(T, 32'h54, T, F, F, F, F, T, 32'h54, F, T, 0));
        tbl.push_back(mk(T, 32'h55, F, F, T, T, F, F, 32'h54, F, F, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].iv, DW'(tbl[i].d), tbl[i].mp, tbl[i].os,
                  tbl[i].rs, tbl[i].fl, tbl[i].clr);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_ov, DW'(tbl[i].e_od),
                    tbl[i].e_is, tbl[i].e_sq, tbl[i].e_sc);
        end

        // Saturation of the stall counter, then clear with stall still present.
        drive(T, DW'(32'h60), F, T, F, F, F);
        tick();
        drive(T, DW'(32'h61), F, T, F, F, F);
        tick();
        drive(T, DW'(32'h62), F, T, F, F, F);
        for (int i = 1; i <= 65540; i++) begin
            tick();
            if (i == 65534) chk("sat_fffe", DW'(stall_cycles), DW'(16'hFFFE));
            if (i == 65535) chk("sat_ffff", DW'(stall_cycles), DW'(16'hFFFF));
        end
        chk_all("sat_hold", T, DW'(32'h60), T, F, 16'hFFFF);
        drive(T, DW'(32'h62), F, T, F, F, T);
        tick();
        chk_all("sat_clr", T, DW'(32'h60), T, F, 16'h0);

        // Async reset while full and squashing.
        drive(F, '0, F, T, F, T, F);
        tick();
        drive(T, DW'(32'h70), F, T, F, F, F);
        tick();
        drive(T, DW'(32'h71), T, T, F, F, F);
        tick();
        drive(T, DW'(32'h72), F, T, F, F, F);
        tick();
        chk_all("pre_rst", T, DW'(32'h70), T, T, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", F, '0, F, F, 16'd0);
        drive(F, '0, F, F, F, F, F);
        #3;
        rst = 1'b1;
        drive(T, DW'(32'h40), F, F, F, F, F);
        tick();
        chk_all("post_rst", T, DW'(32'h40), F, F, 16'd0);

        // Random traffic against the queue model from a clean reset.
        drive(F, '0, F, F, F, F, F);
        #2;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        mq.delete();
        m_sq = 1'b0;
        m_sc = 16'd0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < DW / 32; k++) rd[k*32 +: 32] = $urandom;
            iv  = ($urandom_range(0, 9) < 7);
            mp  = ($urandom_range(0, 9) == 0);
            os  = ($urandom_range(0, 9) < 3);
            rs  = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 99) == 0);
            drive(iv, rd, mp, os, rs, fl, clr);
            m_full = (mq.size() == 2);
            tick();
            if (clr) m_sc = 16'd0;
            else if (iv && m_full && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (fl) begin
                mq.delete();
                m_sq = 1'b0;
            end else begin
                acc = iv && !m_full && !(m_sq && !rs);
                if (mq.size() != 0 && !os) void'(mq.pop_front());
                if (acc) mq.push_back(rd);
                if (acc && mp) m_sq = 1'b1;
                else if (rs) m_sq = 1'b0;
            end
            chk($sformatf("rnd%0d_ov", c), DW'(out_valid), DW'(mq.size() != 0));
            if (mq.size() != 0)
                chk($sformatf("rnd%0d_od", c), out_data, mq[0]);
            chk($sformatf("rnd%0d_is", c), DW'(in_stall), DW'(mq.size() == 2));
            chk($sformatf("rnd%0d_sq", c), DW'(squashing), DW'(m_sq));
            chk($sformatf("rnd%0d_sc", c), DW'(stall_cycles), DW'(m_sc));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
